alu_cmd_sequencer: RTL and testbench

Command-side initiator for the 8-bit ALU. It accepts operation commands over a valid/ready interface and reads operands from a small internal register file or an immediate. It drives the ALU's a/b/opcode inputs, captures the ALU result and carry, and writes the result back. It then returns result and flags over a valid/ready response interface. It is the block that issues work to the combinational ALU and consumes its output.

---
 rtl/alu_cmd_sequencer.sv | 88 ++++++++
 tb/tb_alu_cmd_sequencer.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_cmd_sequencer.sv
// Command-side sequencer for the 8-bit combinational ALU: reads operands from a
// small register file or an immediate, drives the ALU, writes back and responds.
module alu_cmd_sequencer #(
   parameter int WIDTH = 8,
   parameter int NREGS = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [2:0]       cmd_opcode,
   input  logic [1:0]       cmd_dst,
   input  logic [1:0]       cmd_src_a,
   input  logic [1:0]       cmd_src_b,
   input  logic             cmd_use_imm,
   input  logic [WIDTH-1:0] cmd_imm,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   output logic [2:0]       alu_opcode,
   input  logic [WIDTH-1:0] alu_out,
   input  logic             alu_cout,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [WIDTH-1:0] rsp_data,
   output logic             rsp_c_flag,
   output logic             rsp_z_flag,
   output logic [7:0]       cmd_count
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_EXEC = 2'd1;
   localparam logic [1:0] ST_RESP = 2'd2;

   logic [1:0]       state;
   logic [1:0]       dst_q;
   logic [WIDTH-1:0] regs [NREGS];

   // Gated by rst_n so nothing is accepted while reset is held.
   assign cmd_ready = rst_n && (state == ST_IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         dst_q      <= '0;
         alu_a      <= '0;
         alu_b      <= '0;
         alu_opcode <= '0;
         rsp_valid  <= 1'b0;
         rsp_data   <= '0;
         rsp_c_flag <= 1'b0;
         rsp_z_flag <= 1'b0;
         cmd_count  <= '0;
         for (int i = 0; i < NREGS; i++) begin
            regs[i] <= '0;
         end
      end else begin
         case (state)
            ST_IDLE: begin
               if (cmd_valid) begin
                  alu_a      <= regs[cmd_src_a];
                  alu_b      <= cmd_use_imm ? cmd_imm : regs[cmd_src_b];
                  alu_opcode <= cmd_opcode;
                  dst_q      <= cmd_dst;
                  state      <= ST_EXEC;
               end
            end
            ST_EXEC: begin
               // The ALU settles combinationally during this single cycle.
               regs[dst_q] <= alu_out;
               rsp_data    <= alu_out;
               rsp_c_flag  <= alu_cout;
               rsp_z_flag  <= (alu_out == '0);
               rsp_valid   <= 1'b1;
               state       <= ST_RESP;
            end
            ST_RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  cmd_count <= cmd_count + 8'd1;
                  state     <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Scoreboard bench for alu_cmd_sequencer with a behavioural ALU attached to
// its a/b/opcode outputs and a reference model of the register file.
module tb_alu_cmd_sequencer;

   typedef struct packed {
      logic [7:0] a;
      logic [7:0] b;
      logic [2:0] op;
      logic [7:0] data;
      logic       c;
      logic       z;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [2:0] cmd_opcode;
   logic [1:0] cmd_dst;
   logic [1:0] cmd_src_a;
   logic [1:0] cmd_src_b;
   logic       cmd_use_imm;
   logic [7:0] cmd_imm;
   logic [7:0] alu_a;
   logic [7:0] alu_b;
   logic [2:0] alu_opcode;
   logic [7:0] alu_out;
   logic       alu_cout;
   logic       rsp_valid;
   logic       rsp_ready;
   logic [7:0] rsp_data;
   logic       rsp_c_flag;
   logic       rsp_z_flag;
   logic [7:0] cmd_count;

   int         total = 0;
   int         bad = 0;
   int         cyc = 0;
   logic [7:0] mregs [4];
   logic [7:0] expCount;
   exp_t       sbq [$];

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   alu_cmd_sequencer #(.WIDTH(8), .NREGS(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_opcode(cmd_opcode),
      .cmd_dst(cmd_dst), .cmd_src_a(cmd_src_a), .cmd_src_b(cmd_src_b),
      .cmd_use_imm(cmd_use_imm), .cmd_imm(cmd_imm),
      .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode),
      .alu_out(alu_out), .alu_cout(alu_cout),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
      .rsp_c_flag(rsp_c_flag), .rsp_z_flag(rsp_z_flag), .cmd_count(cmd_count)
   );

   // Reference ALU: {cout, out}; sub reports borrow, logic ops report no carry.
   function automatic logic [8:0] aluModel(input logic [2:0] op, input logic [7:0] a,
                                           input logic [7:0] b);
      logic [8:0] r;
      r = '0;
      case (op)
         3'd0: r = {1'b0, a} + {1'b0, b};
         3'd1: r = {(a < b), 8'(a - b)};
         3'd2: r = {1'b0, a & b};
         3'd3: r = {1'b0, a | b};
         3'd4: r = {1'b0, a ^ b};
         3'd5: r = {1'b0, 7'd0, (a > b)};
         3'd6: r = {1'b0, a[6:0], 1'b0};
         default: r = {1'b0, b[6:0], 1'b0};
      endcase
      return r;
   endfunction

   always_comb {alu_cout, alu_out} = aluModel(alu_opcode, alu_a, alu_b);

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic clearModel();
      for (int i = 0; i < 4; i++) mregs[i] = '0;
      expCount = '0;
      sbq.delete();
   endtask

   task automatic applyStimulus(input logic [2:0] op, input logic [1:0] dst, input logic [1:0] sa,
                                input logic [1:0] sb, input logic useImm, input logic [7:0] imm,
                                output int acceptCyc);
      int         n;
      exp_t       e;
      logic [8:0] r;
      @(negedge clk);
      cmd_opcode  = op;
      cmd_dst     = dst;
      cmd_src_a   = sa;
      cmd_src_b   = sb;
      cmd_use_imm = useImm;
      cmd_imm     = imm;
      cmd_valid   = 1'b1;
      n = 0;
      while (!cmd_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!cmd_ready) begin
         checkOutput("accept_timeout", 32'd0, 32'd1);
         cmd_valid = 1'b0;
         acceptCyc = -1;
         return;
      end
      @(posedge clk);
      #1;
      acceptCyc = cyc;
      cmd_valid = 1'b0;
      e.a  = mregs[sa];
      e.b  = useImm ? imm : mregs[sb];
      e.op = op;
      r = aluModel(op, e.a, e.b);
      e.data = r[7:0];
      e.c    = r[8];
      e.z    = (r[7:0] == 8'd0);
      sbq.push_back(e);
      mregs[dst] = r[7:0];
   endtask

   // Follows one accepted command through EXEC and RESP; holdCycles > 0 expects
   // rsp_ready to be held low by the caller for that many extra cycles.
   task automatic collectResponse(input int holdCycles, output int doneCyc);
      exp_t e;
      @(negedge clk);
      checkOutput("exec_rsp_valid", rsp_valid, 0);
      checkOutput("exec_cmd_ready", cmd_ready, 0);
      if (sbq.size() == 0) begin
         checkOutput("sb_empty", 32'd0, 32'd1);
         doneCyc = -1;
         return;
      end
      e = sbq.pop_front();
      checkOutput("alu_a", alu_a, e.a);
      checkOutput("alu_b", alu_b, e.b);
      checkOutput("alu_opcode", alu_opcode, e.op);
      @(negedge clk);
      checkOutput("rsp_valid_lat", rsp_valid, 1);
      checkOutput("rsp_data", rsp_data, e.data);
      checkOutput("rsp_c", rsp_c_flag, e.c);
      checkOutput("rsp_z", rsp_z_flag, e.z);
      for (int i = 0; i < holdCycles; i++) begin
         @(negedge clk);
         checkOutput("hold_valid", rsp_valid, 1);
         checkOutput("hold_data", rsp_data, e.data);
         checkOutput("hold_c", rsp_c_flag, e.c);
         checkOutput("hold_z", rsp_z_flag, e.z);
         checkOutput("hold_cmd_ready", cmd_ready, 0);
         checkOutput("hold_count", cmd_count, expCount);
      end
      rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      doneCyc  = cyc;
      expCount = expCount + 8'd1;
      checkOutput("rsp_valid_drop", rsp_valid, 0);
      checkOutput("cmd_count", cmd_count, expCount);
   endtask

   task automatic runCmd(input logic [2:0] op, input logic [1:0] dst, input logic [1:0] sa,
                         input logic [1:0] sb, input logic useImm, input logic [7:0] imm);
      int acc;
      int done;
      applyStimulus(op, dst, sa, sb, useImm, imm, acc);
      if (acc >= 0) collectResponse(0, done);
   endtask

   task automatic doReset();
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      checkOutput("rst_cmd_ready", cmd_ready, 0);
      checkOutput("rst_rsp_valid", rsp_valid, 0);
      checkOutput("rst_count", cmd_count, 0);
      checkOutput("rst_rsp_data", rsp_data, 0);
      checkOutput("rst_alu_a", alu_a, 0);
      checkOutput("rst_alu_b", alu_b, 0);
      checkOutput("rst_alu_op", alu_opcode, 0);
      clearModel();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      checkOutput("post_rst_cmd_ready", cmd_ready, 1);
      checkOutput("post_rst_rsp_valid", rsp_valid, 0);
   endtask

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      int acc;
      int done;
      int prevAcc;
      rst_n = 1'b0;
      cmd_valid = 1'b0;
      cmd_opcode = '0;
      cmd_dst = '0;
      cmd_src_a = '0;
      cmd_src_b = '0;
      cmd_use_imm = 1'b0;
      cmd_imm = '0;
      rsp_ready = 1'b1;
      clearModel();
      doReset();

      // Immediate load, add with carry-out to zero, src==dst register add.
      runCmd(3'd3, 2'd2, 2'd0, 2'd0, 1'b1, 8'hFF);
      runCmd(3'd0, 2'd3, 2'd2, 2'd0, 1'b1, 8'h01);
      runCmd(3'd3, 2'd1, 2'd0, 2'd0, 1'b1, 8'h10);
      runCmd(3'd0, 2'd1, 2'd1, 2'd1, 1'b0, 8'h00);
      runCmd(3'd3, 2'd0, 2'd1, 2'd0, 1'b1, 8'h00);
      runCmd(3'd1, 2'd0, 2'd1, 2'd2, 1'b0, 8'h00);
      runCmd(3'd1, 2'd3, 2'd2, 2'd1, 1'b0, 8'h00);
      runCmd(3'd2, 2'd3, 2'd2, 2'd0, 1'b1, 8'h5A);
      runCmd(3'd4, 2'd3, 2'd3, 2'd2, 1'b0, 8'h00);
      runCmd(3'd5, 2'd0, 2'd2, 2'd1, 1'b0, 8'h00);
      runCmd(3'd5, 2'd0, 2'd1, 2'd2, 1'b0, 8'h00);
      runCmd(3'd6, 2'd3, 2'd2, 2'd0, 1'b1, 8'h00);
      runCmd(3'd7, 2'd3, 2'd0, 2'd0, 1'b1, 8'hC3);

      // Backpressure with a competing command held valid throughout.
      applyStimulus(3'd0, 2'd2, 2'd1, 2'd0, 1'b1, 8'h07, acc);
      rsp_ready   = 1'b0;
      cmd_opcode  = 3'd4;
      cmd_dst     = 2'd1;
      cmd_src_a   = 2'd2;
      cmd_src_b   = 2'd3;
      cmd_use_imm = 1'b0;
      cmd_valid   = 1'b1;
      collectResponse(5, done);
      applyStimulus(3'd4, 2'd1, 2'd2, 2'd3, 1'b0, 8'h00, acc);
      checkOutput("bp_next_accept", acc - done, 1);
      collectResponse(0, done);

      // Reset in the middle of RESP, then read back every register as zero.
      applyStimulus(3'd3, 2'd0, 2'd0, 2'd0, 1'b1, 8'hAA, acc);
      rsp_ready = 1'b0;
      repeat (2) @(negedge clk);
      checkOutput("pre_rst_valid", rsp_valid, 1);
      doReset();
      rsp_ready = 1'b1;
      for (int r = 0; r < 4; r++) runCmd(3'd3, 2'(r), 2'(r), 2'd0, 1'b1, 8'h00);

      // 257 back-to-back commands: 3-cycle spacing and count wrap.
      doReset();
      prevAcc = -1;
      for (int i = 0; i < 257; i++) begin
         applyStimulus(3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
                       2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                       1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), acc);
         if (acc < 0) break;
         if (prevAcc >= 0) checkOutput("spacing", acc - prevAcc, 3);
         prevAcc = acc;
         collectResponse(0, done);
      end
      checkOutput("count_wrap", cmd_count, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
